// File: rtl/ifu_pkg.sv
// Shared IFU types: cache<->instruction-memory fill structs and the fill controller
// state encoding and sizing constants.
package ifu_pkg;

    localparam int I_MEM_DEPTH_DFLT = 4096;
    localparam int I_MEM_BEATS      = 4;

    typedef struct packed {
        logic        fill_requested_address_valid;
        logic [31:0] fill_requested_address;
    } t_cache2i_mem_req;

    typedef struct packed {
        logic         valid;
        logic [31:0]  address;
        logic [127:0] filled_instruction;
    } t_i_mem2cache_rsp;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        RESP
    } t_i_mem_fill_states;

endpackage

// File: rtl/i_mem_fill_ctrl.sv
// Instruction-memory fill controller: turns cache-line fill requests into 4-beat word
// reads and shares the single memory port with a program-loader write port.
module i_mem_fill_ctrl
    import ifu_pkg::*;
#(
    parameter int I_MEM_DEPTH = I_MEM_DEPTH_DFLT,
    parameter int I_MEM_AW    = $clog2(I_MEM_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  t_cache2i_mem_req    cache2i_mem_req,
    output t_i_mem2cache_rsp    i_mem2cache_rsp,
    input  logic                ld_req_valid,
    input  logic [31:0]         ld_req_addr,
    input  logic [31:0]         ld_req_data,
    output logic                ld_req_ready,
    output logic                mem_en,
    output logic                mem_we,
    output logic [I_MEM_AW-1:0] mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    output logic                busy,
    output logic                fill_overrun
);

    localparam int LINE_W = 32 * I_MEM_BEATS;

    t_i_mem_fill_states state, state_nxt;
    logic [1:0]         beat;
    logic [27:0]        base_q;
    logic [27:0]        pend_addr;
    logic               pend_vld;
    logic               overrun_q;
    logic               rd_vld_p1;
    logic [1:0]         rd_beat_p1;
    logic [LINE_W-1:0]  line_q;
    logic [LINE_W-1:0]  line_nxt;
    t_i_mem2cache_rsp   rsp_q;
    logic               fill_pulse;
    logic               take_fill;
    logic               ld_hs;
    logic               unused_ok;

    assign fill_pulse   = cache2i_mem_req.fill_requested_address_valid;
    assign take_fill    = (state == IDLE) && (pend_vld || fill_pulse);
    assign ld_req_ready = (state == IDLE) && !pend_vld && !fill_pulse && !rst;
    assign ld_hs        = ld_req_ready && ld_req_valid;

    assign i_mem2cache_rsp = rsp_q;
    assign busy            = (state != IDLE) || pend_vld;
    assign fill_overrun    = overrun_q;

    // Line offset bits and address bits above the memory size are meaningless here.
    assign unused_ok = ^{cache2i_mem_req.fill_requested_address[3:0],
                         ld_req_addr[31:I_MEM_AW+2], ld_req_addr[1:0]};

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (take_fill) begin
                    state_nxt = READ;
                end else if (ld_hs) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = ld_req_addr[I_MEM_AW+1:2];
                    mem_wdata = ld_req_data;
                end
            end
            READ: begin
                mem_en   = 1'b1;
                mem_addr = {base_q[I_MEM_AW-3:0], beat};
                if (beat == 2'd3) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data lands one cycle after its beat; slot it into the line by beat index.
    always_comb begin
        line_nxt = line_q;
        if (rd_vld_p1) begin
            line_nxt[32*rd_beat_p1 +: 32] = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= 2'd0;
            base_q     <= '0;
            pend_addr  <= '0;
            pend_vld   <= 1'b0;
            overrun_q  <= 1'b0;
            rd_vld_p1  <= 1'b0;
            rd_beat_p1 <= 2'd0;
            line_q     <= '0;
            rsp_q      <= '0;
        end else begin
            state      <= state_nxt;
            rd_vld_p1  <= (state == READ);
            rd_beat_p1 <= beat;
            line_q     <= line_nxt;
            if (state == READ) begin
                beat <= beat + 2'd1;
            end
            // Response is registered straight from the final capture, so it is valid in RESP.
            rsp_q.valid <= (state == DRAIN);
            if (state == DRAIN) begin
                rsp_q.address            <= {base_q, 4'b0000};
                rsp_q.filled_instruction <= line_nxt;
            end
            if (take_fill) begin
                base_q <= pend_vld ? pend_addr
                                   : cache2i_mem_req.fill_requested_address[31:4];
            end
            // Pending is older than any pulse arriving alongside it, so it is served first.
            if (state == IDLE) begin
                if (pend_vld) begin
                    pend_vld <= fill_pulse;
                    if (fill_pulse) begin
                        pend_addr <= cache2i_mem_req.fill_requested_address[31:4];
                    end
                end
            end else if (fill_pulse) begin
                if (pend_vld) begin
                    overrun_q <= 1'b1;
                end else begin
                    pend_vld  <= 1'b1;
                    pend_addr <= cache2i_mem_req.fill_requested_address[31:4];
                end
            end
        end
    end

endmodule

// File: tb/tb_i_mem_fill_ctrl.sv
// Bench for i_mem_fill_ctrl: word memory model plus a reference image of memory
// from which expected bursts, lines and handshakes are derived.
module tb_i_mem_fill_ctrl;

    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic                     clk;
    logic                     rst;
    ifu_pkg::t_cache2i_mem_req req;
    ifu_pkg::t_i_mem2cache_rsp rsp;
    logic                     ld_req_valid;
    logic [31:0]              ld_req_addr;
    logic [31:0]              ld_req_data;
    logic                     ld_req_ready;
    logic                     mem_en;
    logic                     mem_we;
    logic [AW-1:0]            mem_addr;
    logic [31:0]              mem_wdata;
    logic [31:0]              mem_rdata;
    logic                     busy;
    logic                     fill_overrun;
    logic                     mem_clr;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] mem_arr [0:DEPTH-1];
    bit          written [0:DEPTH-1];

    i_mem_fill_ctrl #(.I_MEM_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .cache2i_mem_req (req),
        .i_mem2cache_rsp (rsp),
        .ld_req_valid    (ld_req_valid),
        .ld_req_addr     (ld_req_addr),
        .ld_req_data     (ld_req_data),
        .ld_req_ready    (ld_req_ready),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .busy            (busy),
        .fill_overrun    (fill_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Memory model; returns noise whenever no read was issued the cycle before.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) written[i] <= 1'b0;
        end else if (mem_en && mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we)
            mem_rdata <= written[mem_addr] ? mem_arr[mem_addr] : init_word(int'(mem_addr));
        else
            mem_rdata <= $urandom;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_write(input logic [31:0] a, input logic [31:0] d);
        logic [AW-1:0] w;
        w = AW'(a >> 2);
        ld_req_valid = 1'b1;
        ld_req_addr  = a;
        ld_req_data  = d;
        @(negedge clk);
        checks++;
        if (ld_req_ready !== 1'b1) begin
            errors++; $display("FAIL ld_ready: got %b expected 1", ld_req_ready);
        end
        checks++;
        if ({mem_en, mem_we} !== 2'b11) begin
            errors++; $display("FAIL ld_en_we: got %b expected 11", {mem_en, mem_we});
        end
        checks++;
        if (mem_addr !== w || mem_wdata !== d) begin
            errors++;
            $display("FAIL ld_addr_data: got %h/%h expected %h/%h", mem_addr, mem_wdata, w, d);
        end
        ref_mem[w] = d;
        next_cycle();
        ld_req_valid = 1'b0;
    endtask

    // One fill from an idle controller, optionally with a loader request held alongside.
    task automatic fill_and_check(input logic [31:0] a, input bit with_ld, input string nm);
        int            wbase;
        logic [127:0]  exp_line;
        logic [31:0]   ld_a, ld_d;
        logic [AW-1:0] ld_w;
        bit            exp_en;
        wbase = int'((a % 32'(DEPTH * 4)) / 32'd16) * 4;
        for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = ref_mem[wbase + k];
        ld_a = $urandom;
        ld_d = $urandom;
        ld_w = AW'(ld_a >> 2);
        req.fill_requested_address_valid = 1'b1;
        req.fill_requested_address       = a;
        ld_req_valid = with_ld;
        ld_req_addr  = ld_a;
        ld_req_data  = ld_d;
        for (int t = 0; t <= 7; t++) begin
            @(negedge clk);
            exp_en = (t >= 1 && t <= 4) || (t == 7 && with_ld);
            checks++;
            if (mem_en !== exp_en) begin
                errors++; $display("FAIL %s mem_en t=%0d: got %b expected %b", nm, t, mem_en, exp_en);
            end
            if (t >= 1 && t <= 4) begin
                checks++;
                if (mem_we !== 1'b0 || mem_addr !== AW'(wbase + t - 1)) begin
                    errors++;
                    $display("FAIL %s beat t=%0d: got we=%b addr=%h expected we=0 addr=%h",
                             nm, t, mem_we, mem_addr, AW'(wbase + t - 1));
                end
            end
            if (t == 7 && with_ld) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== ld_w || mem_wdata !== ld_d) begin
                    errors++;
                    $display("FAIL %s ld_after_fill: got we=%b %h/%h expected we=1 %h/%h",
                             nm, mem_we, mem_addr, mem_wdata, ld_w, ld_d);
                end
            end
            checks++;
            if (rsp.valid !== (t == 6)) begin
                errors++; $display("FAIL %s valid t=%0d: got %b expected %b", nm, t, rsp.valid, t == 6);
            end
            if (t == 6) begin
                checks++;
                if (rsp.address !== (a & 32'hFFFF_FFF0) || rsp.filled_instruction !== exp_line) begin
                    errors++;
                    $display("FAIL %s rsp: got %h %h expected %h %h", nm, rsp.address,
                             rsp.filled_instruction, a & 32'hFFFF_FFF0, exp_line);
                end
            end
            checks++;
            if (ld_req_ready !== (t == 7)) begin
                errors++; $display("FAIL %s ld_ready t=%0d: got %b expected %b", nm, t, ld_req_ready, t == 7);
            end
            checks++;
            if (busy !== (t >= 1 && t <= 6)) begin
                errors++; $display("FAIL %s busy t=%0d: got %b", nm, t, busy);
            end
            next_cycle();
            req.fill_requested_address_valid = 1'b0;
        end
        if (with_ld) ref_mem[ld_w] = ld_d;
        ld_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ld_req_valid = 1'b1;
        ld_req_addr  = 32'h0000_0040;
        ld_req_data  = 32'hDEAD_BEEF;
        req.fill_requested_address_valid = 1'b1;
        req.fill_requested_address       = 32'h0000_0080;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (rsp !== '0 || mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 ||
                mem_wdata !== '0 || busy !== 1'b0 || fill_overrun !== 1'b0 || ld_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got v=%b en=%b we=%b a=%h busy=%b ovr=%b rdy=%b expected all 0",
                         rsp.valid, mem_en, mem_we, mem_addr, busy, fill_overrun, ld_req_ready);
            end
        end
        next_cycle();
        rst = 1'b0;
        ld_req_valid = 1'b0;
        req.fill_requested_address_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (ld_req_ready !== 1'b1 || busy !== 1'b0 || mem_en !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got rdy=%b busy=%b en=%b expected 1 0 0",
                         ld_req_ready, busy, mem_en);
            end
            next_cycle();
        end
    endtask

    task automatic test_single_fill();
        ld_write(32'h40, 32'h1111_1111);
        ld_write(32'h44, 32'h2222_2222);
        ld_write(32'h48, 32'h3333_3333);
        ld_write(32'h4C, 32'h4444_4444);
        fill_and_check(32'h48, 1'b0, "single_fill");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) ld_write(32'h10 + 32'(4 * i), $urandom);
        fill_and_check(32'h0001_0010, 1'b0, "wrap_hi");
        fill_and_check(32'h0000_0010, 1'b0, "wrap_lo");
    endtask

    task automatic test_arbitration();
        fill_and_check($urandom, 1'b1, "arbitration");
    endtask

    task automatic test_loader_stream();
        for (int i = 0; i < 8; i++) ld_write(32'h100 + 32'(4 * i), $urandom);
        fill_and_check(32'h100, 1'b0, "stream_fill0");
        fill_and_check(32'h114, 1'b0, "stream_fill1");
    endtask

    task automatic test_pending_overrun();
        logic [31:0]  a_addr, b_addr;
        int           wa, wb;
        logic [127:0] la, lb;
        bit           exp_en, exp_v;
        a_addr = $urandom;
        b_addr = $urandom;
        wa = int'(AW'(a_addr >> 4) << 2) & (DEPTH - 1);
        wb = int'(AW'(b_addr >> 4) << 2) & (DEPTH - 1);
        for (int k = 0; k < 4; k++) begin
            la[32*k +: 32] = ref_mem[wa + k];
            lb[32*k +: 32] = ref_mem[wb + k];
        end
        for (int t = 0; t <= 14; t++) begin
            req.fill_requested_address_valid = (t == 0 || t == 2 || t == 3);
            req.fill_requested_address = (t == 0) ? a_addr : (t == 2) ? b_addr : $urandom;
            @(negedge clk);
            exp_en = (t >= 1 && t <= 4) || (t >= 8 && t <= 11);
            checks++;
            if (mem_en !== exp_en) begin
                errors++; $display("FAIL pend mem_en t=%0d: got %b expected %b", t, mem_en, exp_en);
            end
            if (t >= 1 && t <= 4) begin
                checks++;
                if (mem_addr !== AW'(wa + t - 1)) begin
                    errors++; $display("FAIL pend beatA t=%0d: got %h expected %h", t, mem_addr, AW'(wa + t - 1));
                end
            end
            if (t >= 8 && t <= 11) begin
                checks++;
                if (mem_addr !== AW'(wb + t - 8)) begin
                    errors++; $display("FAIL pend beatB t=%0d: got %h expected %h", t, mem_addr, AW'(wb + t - 8));
                end
            end
            exp_v = (t == 6 || t == 13);
            checks++;
            if (rsp.valid !== exp_v) begin
                errors++; $display("FAIL pend valid t=%0d: got %b expected %b", t, rsp.valid, exp_v);
            end
            if (t == 6 || t == 13) begin
                checks++;
                if (rsp.address !== ((t == 6 ? a_addr : b_addr) & 32'hFFFF_FFF0) ||
                    rsp.filled_instruction !== (t == 6 ? la : lb)) begin
                    errors++;
                    $display("FAIL pend rsp t=%0d: got %h %h expected %h %h", t, rsp.address,
                             rsp.filled_instruction, (t == 6 ? a_addr : b_addr) & 32'hFFFF_FFF0,
                             (t == 6 ? la : lb));
                end
            end
            checks++;
            if (fill_overrun !== (t >= 4)) begin
                errors++; $display("FAIL overrun t=%0d: got %b expected %b", t, fill_overrun, t >= 4);
            end
            checks++;
            if (busy !== (t >= 1 && t <= 13) || ld_req_ready !== (t == 14)) begin
                errors++;
                $display("FAIL pend busy_rdy t=%0d: got %b%b expected %b%b", t, busy, ld_req_ready,
                         t >= 1 && t <= 13, t == 14);
            end
            next_cycle();
        end
        req.fill_requested_address_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] last_a;
        last_a = 32'h200;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                last_a = $urandom;
                ld_write(last_a, $urandom);
            end else begin
                fill_and_check(last_a ^ ($urandom & 32'hFFFF_C000), 1'($urandom_range(0, 1)), "rand_fill");
            end
        end
        @(negedge clk);
        checks++;
        if (fill_overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_sticky: got %b expected 1", fill_overrun);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        for (int t = 0; t <= 14; t++) begin
            req.fill_requested_address_valid = (t == 0 || t == 1);
            req.fill_requested_address       = $urandom;
            rst          = (t == 3 || t == 4);
            ld_req_valid = (t == 4);
            ld_req_addr  = $urandom;
            ld_req_data  = $urandom;
            @(negedge clk);
            checks++;
            if (rsp.valid !== 1'b0) begin
                errors++; $display("FAIL rst_mid valid t=%0d: got %b expected 0", t, rsp.valid);
            end
            if (t == 4) begin
                checks++;
                if (rsp !== '0 || mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 ||
                    mem_wdata !== '0 || busy !== 1'b0 || fill_overrun !== 1'b0 || ld_req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_mid outputs: got en=%b busy=%b ovr=%b rdy=%b expected all 0",
                             mem_en, busy, fill_overrun, ld_req_ready);
                end
            end
            if (t >= 5) begin
                checks++;
                if (ld_req_ready !== 1'b1 || mem_en !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_mid idle t=%0d: got rdy=%b en=%b busy=%b expected 1 0 0",
                             t, ld_req_ready, mem_en, busy);
                end
            end
            next_cycle();
        end
        rst = 1'b0;
        ld_req_valid = 1'b0;
        req.fill_requested_address_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        mem_clr      = 1'b1;
        rst          = 1'b1;
        ld_req_valid = 1'b0;
        ld_req_addr  = '0;
        ld_req_data  = '0;
        req          = '0;
        next_cycle();
        mem_clr = 1'b0;
        test_reset();
        test_single_fill();
        test_wrap();
        test_arbitration();
        test_loader_stream();
        test_pending_overrun();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
